// File: rtl/sfp_pkg.sv
// sfp_array shared types.
// FSM state encoding for the tile sequencer.
package sfp_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    POST = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/sfp_lane.sv
// sfp_array single lane.
// Saturating signed accumulator with threshold-ReLU and clear.
module sfp_lane #(
  parameter int bw      = 8,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      operand,
  input  logic [psum_bw-1:0] thres,
  input  logic               acc_en,
  input  logic               relu_apply,
  input  logic               clr,
  output logic [psum_bw-1:0] psum,
  output logic               sat
);

  localparam logic [psum_bw-1:0] PMAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] PMIN = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw-1:0] psum_q;
  logic               sat_q;
  logic [psum_bw:0]   sum;
  logic               ovf;
  logic [psum_bw-1:0] clamped;
  logic               below;

  // Wide sum, overflow detect and clamp.
  always_comb begin
    sum = {psum_q[psum_bw-1], psum_q}
        + {{(psum_bw+1-bw){operand[bw-1]}}, operand};
    ovf = sum[psum_bw] ^ sum[psum_bw-1];
    clamped = sum[psum_bw-1:0];
    if (ovf) begin
      clamped = sum[psum_bw] ? PMIN : PMAX;
    end
    below = $signed(psum_q) < $signed(thres);
  end

  // Accumulate, apply ReLU, or clear on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_q <= '0;
      sat_q  <= 1'b0;
    end else if (clr) begin
      psum_q <= '0;
      sat_q  <= 1'b0;
    end else if (acc_en) begin
      psum_q <= clamped;
      sat_q  <= sat_q | ovf;
    end else if (relu_apply && below) begin
      psum_q <= '0;
    end
  end

  assign psum = psum_q;
  assign sat  = sat_q;

endmodule

// File: rtl/sfp_array.sv
// sfp_array top: tile sequencer and lane array.
// Accumulates beats, applies ReLU, holds result until consumed.
module sfp_array
  import sfp_pkg::*;
#(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw-1:0]      in,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   relu_en,
  input  logic [psum_bw-1:0]     thres,
  output logic [col*psum_bw-1:0] out,
  output logic [col-1:0]         out_sat,
  output logic                   out_valid,
  input  logic                   out_ready
);

  state_t             state_q;
  state_t             state_d;
  logic               relu_q;
  logic [psum_bw-1:0] thres_q;
  logic               accept;
  logic               relu_apply;
  logic               clr;

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == HOLD);
  assign accept     = in_valid && in_ready;
  assign relu_apply = (state_q == POST) && relu_q;
  assign clr        = (state_q == HOLD) && out_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACC;
    else       state_q <= state_d;
  end

  // Next-state: last beat -> POST -> HOLD -> ACC on handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (accept && in_last) state_d = POST;
      POST:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Capture tile post-processing controls with the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      relu_q  <= 1'b0;
      thres_q <= '0;
    end else if (accept && in_last) begin
      relu_q  <= relu_en;
      thres_q <= thres;
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(
      .bw      (bw),
      .psum_bw (psum_bw)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .operand    (in[i*bw +: bw]),
      .thres      (thres_q),
      .acc_en     (accept),
      .relu_apply (relu_apply),
      .clr        (clr),
      .psum       (out[i*psum_bw +: psum_bw]),
      .sat        (out_sat[i])
    );
  end

endmodule

// File: tb/tb_sfp_array.sv
// sfp_array testbench.
// Scoreboard of expected tiles, popped when out_valid rises.
module tb_sfp_array;

  localparam int BW  = 8;
  localparam int PBW = 16;
  localparam int COL = 4;

  typedef struct packed {
    logic [COL*PBW-1:0] res;
    logic [COL-1:0]     sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [COL*BW-1:0]  in = '0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               in_ready;
  logic               relu_en = 1'b0;
  logic [PBW-1:0]     thres = '0;
  logic [COL*PBW-1:0] out;
  logic [COL-1:0]     out_sat;
  logic               out_valid;
  logic               out_ready = 1'b0;

  exp_t              sbq[$];
  logic [COL*BW-1:0] beats[$];
  int passed = 0;
  int total  = 0;

  sfp_array #(.bw(BW), .psum_bw(PBW), .col(COL)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .relu_en(relu_en),
    .thres(thres), .out(out), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [COL*BW-1:0] pk(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic model(input bit relu, input int th);
    exp_t e;
    int s;
    bit st;
    logic signed [BW-1:0] v;
    e = '0;
    for (int l = 0; l < COL; l++) begin
      s = 0;
      st = 0;
      foreach (beats[b]) begin
        v = beats[b][l*BW +: BW];
        s += int'(v);
        if (s > 32767) begin s = 32767; st = 1; end
        if (s < -32768) begin s = -32768; st = 1; end
      end
      if (relu && s < th) s = 0;
      e.res[l*PBW +: PBW] = s[PBW-1:0];
      e.sat[l] = st;
    end
    sbq.push_back(e);
  endtask

  task automatic send_tile(input bit relu, input int th, input int gap);
    model(relu, th);
    foreach (beats[b]) begin
      if (gap > 0) begin
        repeat ($urandom_range(gap, 0)) begin
          in_last = 1'b1;
          relu_en = ~relu;
          @(posedge clk); #1;
        end
      end
      in       = beats[b];
      in_valid = 1'b1;
      in_last  = (b == beats.size() - 1);
      relu_en  = relu;
      thres    = th[PBW-1:0];
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++;
    if (out !== '0) $display("FAIL reset_out got %h want 0", out);
    else passed++;
    total++;
    if (out_sat !== '0) $display("FAIL reset_sat got %b want 0", out_sat);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_ov got %b want 0", out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ir got %b want 1", in_ready);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sum();
    exp_t e;
    bit ok;
    int cyc;
    exp_t hand;
    beats = {pk(1,-2,3,-4), pk(1,-2,3,-4), pk(1,-2,3,-4)};
    send_tile(0, 0, 0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL sum_post got ov=%b ir=%b want 0 0", out_valid, in_ready);
    else passed++;
    wait_valid(ok, cyc);
    total++;
    if (!ok || cyc != 1) $display("FAIL sum_latency got %0d want 1", cyc);
    else passed++;
    e = sbq.pop_front();
    hand.res = {16'hFFF4, 16'd9, 16'hFFFA, 16'd3};
    hand.sat = '0;
    total++;
    if (out !== e.res || e.res !== hand.res)
      $display("FAIL sum_out got %h want %h", out, hand.res);
    else passed++;
    total++;
    if (out_sat !== e.sat) $display("FAIL sum_sat got %b want %b", out_sat, e.sat);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL sum_release got ir=%b ov=%b want 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_relu();
    exp_t e;
    bit ok;
    int cyc;
    int ths[2] = '{0, 5};
    foreach (ths[t]) begin
      beats = {pk(1,-2,3,-4), pk(1,-2,3,-4), pk(1,-2,3,-4)};
      send_tile(1, ths[t], 0);
      wait_valid(ok, cyc);
      e = sbq.pop_front();
      total++;
      if (!ok) $display("FAIL relu_timeout got none want out_valid");
      else passed++;
      total++;
      if (out !== e.res)
        $display("FAIL relu_out th=%0d got %h want %h", ths[t], out, e.res);
      else passed++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_sat();
    exp_t e;
    bit ok;
    int cyc;
    beats = {};
    for (int i = 0; i < 300; i++) beats.push_back(pk(127, -128, 0, 1));
    send_tile(0, 0, 0);
    wait_valid(ok, cyc);
    e = sbq.pop_front();
    total++;
    if (!ok || out !== e.res || out[31:0] !== 32'h8000_7FFF)
      $display("FAIL sat_out got %h want %h", out, e.res);
    else passed++;
    total++;
    if (out_sat !== e.sat || out_sat !== 4'b0011)
      $display("FAIL sat_flag got %b want 0011", out_sat);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    int cyc;
    beats = {pk(10,20,-30,40), pk(1,1,1,1)};
    send_tile(0, 0, 0);
    wait_valid(ok, cyc);
    e = sbq.pop_front();
    for (int i = 0; i < 10; i++) begin
      in = pk(9,9,9,9);
      in_valid = 1'b1;
      in_last = 1'b1;
      @(posedge clk); #1;
      total++;
      if (!ok || out !== e.res || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold cyc%0d got %h ir=%b want %h ir=0",
                 i, out, in_ready, e.res);
      else passed++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    beats = {pk(2,2,2,2)};
    send_tile(0, 0, 0);
    wait_valid(ok, cyc);
    e = sbq.pop_front();
    total++;
    if (!ok || out !== e.res) $display("FAIL bp_next got %h want %h", out, e.res);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    int cyc;
    for (int b = 0; b < 2; b++) begin
      in = pk(7,-7,7,100);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (out !== '0 || out_sat !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid got out=%h ov=%b ir=%b want 0 0 1",
               out, out_valid, in_ready);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    beats = {pk(5,5,5,5)};
    send_tile(0, 0, 0);
    wait_valid(ok, cyc);
    e = sbq.pop_front();
    total++;
    if (!ok || out !== e.res || out !== 64'h0005_0005_0005_0005)
      $display("FAIL rstmid_next got %h want %h", out, e.res);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_gaps();
    exp_t e;
    bit ok;
    int cyc;
    for (int r = 0; r < 3; r++) begin
      beats = {pk(3,-1,50,-60), pk(-8,4,60,-70),
               pk(100,-100,1,2), pk(-5,6,-7,8)};
      send_tile(r[0], 2, 3);
      wait_valid(ok, cyc);
      e = sbq.pop_front();
      total++;
      if (!ok || out !== e.res || out_sat !== e.sat)
        $display("FAIL gaps r%0d got %h want %h", r, out, e.res);
      else passed++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    beats = {pk(-128,127,-1,0)};
    send_tile(1, -1, 0);
    wait_valid(ok, cyc);
    e = sbq.pop_front();
    total++;
    if (!ok || out !== e.res) $display("FAIL single got %h want %h", out, e.res);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sum();
    test_relu();
    test_sat();
    test_backpressure();
    test_reset_mid();
    test_gaps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
